// File: rtl/wash_sched_pkg.sv
// Shared types and constants for the wash-program job scheduler and its queue.
package wash_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int unsigned JOB_W = 2;

    // Entry layout: MSB is the double-wash option, LSB the dry-wash option.
    typedef struct packed {
        logic dbl;
        logic dry;
    } job_t;

    localparam logic [7:0] JOBS_SAT = 8'hFF;
    localparam logic [3:0] ERRS_SAT = 4'hF;

endpackage

// File: rtl/wash_job_fifo.sv
// DEPTH x 2-bit job queue with push, pop and flush; flush wins over both.
module wash_job_fifo
    import wash_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [JOB_W-1:0]         push_data,
    input  logic                     pop,
    output logic [JOB_W-1:0]         pop_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [JOB_W-1:0] mem_q [DEPTH];
    logic [JOB_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign count    = count_q;

endmodule

// File: rtl/wash_job_scheduler.sv
// Queues front-panel wash jobs and sequences them one at a time into the
// Washing_Machine controller (start/config handshake, timeout, counters).
module wash_job_scheduler
    import wash_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT  = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_double,
    input  logic                   req_dry,
    output logic                   req_ready,
    input  logic                   abort,
    input  logic                   clear_fault,
    output logic                   wm_start,
    output logic                   wm_double_wash,
    output logic                   wm_dry_wash,
    input  logic                   wm_done,
    input  logic                   wm_error,
    output logic                   busy,
    output logic                   fault,
    output logic                   job_done,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic [7:0]             jobs_completed,
    output logic [3:0]             error_events
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SCW-1:0] LAUNCH_LAST = SCW'(START_CYCLES - 1);
    localparam logic [TW-1:0]  ARM_LAST    = TW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0]  FULL_COUNT  = CW'(DEPTH);

    state_t           state_q, state_d;
    job_t             cur_q, cur_d;
    logic [SCW-1:0]   launch_cnt_q, launch_cnt_d;
    logic [TW-1:0]    arm_cnt_q, arm_cnt_d;
    logic             wm_start_q, wm_start_d;
    logic             wm_double_q, wm_double_d;
    logic             wm_dry_q, wm_dry_d;
    logic             job_done_q, job_done_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             err_prev_q, err_prev_d;
    logic [7:0]       jobs_q, jobs_d;
    logic [3:0]       errs_q, errs_d;

    logic             push;
    logic             pop;
    logic [JOB_W-1:0] head;
    logic [CW-1:0]    count;

    assign req_ready = (count != FULL_COUNT) && !abort;
    assign push      = req_valid && req_ready;

    wash_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_double, req_dry}),
        .pop       (pop),
        .pop_data  (head),
        .flush     (abort),
        .count     (count)
    );

    // Outputs are registered from the current state, so wm_start trails
    // entry into LAUNCH by one cycle and stays high for START_CYCLES cycles.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        launch_cnt_d = launch_cnt_q;
        arm_cnt_d    = arm_cnt_q;
        wm_start_d   = 1'b0;
        wm_double_d  = 1'b0;
        wm_dry_d     = 1'b0;
        job_done_d   = 1'b0;
        jobs_d       = jobs_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count != '0) && !abort) begin
                    pop          = 1'b1;
                    cur_d        = job_t'(head);
                    launch_cnt_d = '0;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wm_start_d  = 1'b1;
                wm_double_d = cur_q.dbl;
                wm_dry_d    = cur_q.dry;
                if (launch_cnt_q == LAUNCH_LAST) begin
                    arm_cnt_d = '0;
                    state_d   = S_ARM;
                end else begin
                    launch_cnt_d = launch_cnt_q + SCW'(1);
                end
            end
            S_ARM: begin
                wm_double_d = cur_q.dbl;
                if (!wm_done) begin
                    state_d = S_RUN;
                end else if (arm_cnt_q == ARM_LAST) begin
                    wm_double_d = 1'b0;
                    state_d     = S_FAULT;
                end else begin
                    arm_cnt_d = arm_cnt_q + TW'(1);
                end
            end
            S_RUN: begin
                if (wm_done) begin
                    job_done_d = 1'b1;
                    jobs_d     = (jobs_q == JOBS_SAT) ? jobs_q : jobs_q + 8'd1;
                    state_d    = S_IDLE;
                end else begin
                    wm_double_d = cur_q.dbl;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        fault_d    = (state_d == S_FAULT);
        err_prev_d = wm_error;
        errs_d     = errs_q;
        if (wm_error && !err_prev_q && (errs_q != ERRS_SAT)) begin
            errs_d = errs_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            launch_cnt_q <= '0;
            arm_cnt_q    <= '0;
            wm_start_q   <= 1'b0;
            wm_double_q  <= 1'b0;
            wm_dry_q     <= 1'b0;
            job_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            err_prev_q   <= 1'b0;
            jobs_q       <= '0;
            errs_q       <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            launch_cnt_q <= launch_cnt_d;
            arm_cnt_q    <= arm_cnt_d;
            wm_start_q   <= wm_start_d;
            wm_double_q  <= wm_double_d;
            wm_dry_q     <= wm_dry_d;
            job_done_q   <= job_done_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            err_prev_q   <= err_prev_d;
            jobs_q       <= jobs_d;
            errs_q       <= errs_d;
        end
    end

    assign wm_start       = wm_start_q;
    assign wm_double_wash = wm_double_q;
    assign wm_dry_wash    = wm_dry_q;
    assign job_done       = job_done_q;
    assign busy           = busy_q;
    assign fault          = fault_q;
    assign queue_count    = count;
    assign jobs_completed = jobs_q;
    assign error_events   = errs_q;

endmodule

// File: tb/tb_wash_job_scheduler.sv
// Random-stimulus bench comparing the scheduler cycle by cycle against a
// queue-based reference model of the job lifecycle.
module tb_wash_job_scheduler;

    localparam int DEPTH        = 4;
    localparam int START_CYCLES = 2;
    localparam int ACK_TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_double, req_dry, abort, clear_fault;
    logic       wm_done, wm_error;
    logic       req_ready, wm_start, wm_double_wash, wm_dry_wash;
    logic       busy, fault, job_done;
    logic [2:0] queue_count;
    logic [7:0] jobs_completed;
    logic [3:0] error_events;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending jobs, the job in flight and its elapsed time.
    int q[$];
    bit m_active, m_running, m_faulted, err_prev;
    int m_cur, m_age, m_arm;
    bit e_start, e_dbl, e_dry, e_done, e_busy, e_fault;
    int e_jobs, e_errs;

    wash_job_scheduler #(
        .DEPTH        (DEPTH),
        .START_CYCLES (START_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_double     (req_double),
        .req_dry        (req_dry),
        .req_ready      (req_ready),
        .abort          (abort),
        .clear_fault    (clear_fault),
        .wm_start       (wm_start),
        .wm_double_wash (wm_double_wash),
        .wm_dry_wash    (wm_dry_wash),
        .wm_done        (wm_done),
        .wm_error       (wm_error),
        .busy           (busy),
        .fault          (fault),
        .job_done       (job_done),
        .queue_count    (queue_count),
        .jobs_completed (jobs_completed),
        .error_events   (error_events)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_running = 0; m_faulted = 0; err_prev = 0;
        m_cur = 0; m_age = 0; m_arm = 0;
        e_start = 0; e_dbl = 0; e_dry = 0; e_done = 0; e_busy = 0; e_fault = 0;
        e_jobs = 0; e_errs = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit push_ok, pop_ok;
        push_ok = req_valid && (q.size() < DEPTH) && !abort;
        pop_ok  = !m_active && !m_faulted && (q.size() > 0) && !abort;
        e_start = 0; e_dbl = 0; e_dry = 0; e_done = 0;
        if (m_faulted) begin
            if (clear_fault) m_faulted = 0;
        end else if (m_active) begin
            if (m_age < START_CYCLES) begin
                e_start = 1; e_dry = m_cur[0]; e_dbl = m_cur[1];
                m_age++;
            end else if (!m_running) begin
                if (!wm_done) begin
                    m_running = 1; e_dbl = m_cur[1];
                end else if (m_arm + 1 >= ACK_TIMEOUT) begin
                    m_faulted = 1; m_active = 0;
                end else begin
                    m_arm++; e_dbl = m_cur[1];
                end
            end else if (wm_done) begin
                e_done = 1; m_active = 0;
                if (e_jobs < 255) e_jobs++;
            end else begin
                e_dbl = m_cur[1];
            end
        end
        if (abort) begin
            q.delete();
        end else begin
            if (pop_ok) begin
                m_cur = q.pop_front();
                m_active = 1; m_age = 0; m_running = 0; m_arm = 0;
            end
            if (push_ok) q.push_back(int'({req_double, req_dry}));
        end
        if (wm_error && !err_prev && e_errs < 15) e_errs++;
        err_prev = wm_error;
        e_busy  = m_active || m_faulted;
        e_fault = m_faulted;
    endtask

    task automatic check_outputs();
        check_eq("wm_start",       32'(wm_start),       32'(e_start));
        check_eq("wm_double_wash", 32'(wm_double_wash), 32'(e_dbl));
        check_eq("wm_dry_wash",    32'(wm_dry_wash),    32'(e_dry));
        check_eq("job_done",       32'(job_done),       32'(e_done));
        check_eq("busy",           32'(busy),           32'(e_busy));
        check_eq("fault",          32'(fault),          32'(e_fault));
        check_eq("queue_count",    32'(queue_count),    32'(q.size()));
        check_eq("jobs_completed", 32'(jobs_completed), 32'(e_jobs));
        check_eq("error_events",   32'(error_events),   32'(e_errs));
    endtask

    task automatic zero_inputs();
        req_valid = 0; req_double = 0; req_dry = 0; abort = 0;
        clear_fault = 0; wm_done = 0; wm_error = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        #3;
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        check_outputs();
        check_eq("req_ready_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    task automatic run_seg(input int cycles, input int p_valid, input int p_abort,
                           input int p_clear, input int p_done, input int p_err);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_outputs();
            req_valid   = ($urandom_range(99) < p_valid);
            req_double  = $urandom_range(1);
            req_dry     = $urandom_range(1);
            abort       = ($urandom_range(99) < p_abort);
            clear_fault = ($urandom_range(99) < p_clear);
            wm_done     = ($urandom_range(99) < p_done);
            if ($urandom_range(99) < p_err) wm_error = ~wm_error;
            #1;
            check_eq("req_ready", 32'(req_ready), 32'((q.size() < DEPTH) && !abort));
            model_step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        check_eq("req_ready_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_step();

        run_seg(400, 60, 2, 10, 50, 10);
        do_reset();
        run_seg(600, 70, 0, 3, 95, 5);
        do_reset();
        run_seg(3000, 90, 1, 20, 50, 20);
        do_reset();
        run_seg(300, 30, 3, 15, 30, 8);
        do_reset();
        run_seg(200, 50, 0, 0, 100, 0);
        run_seg(200, 40, 2, 30, 20, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wash_job_scheduler.md
# wash_job_scheduler

Queues wash-program requests from the front panel and sequences them one at a time into the `Washing_Machine` controller. It drives that controller's `start`, `double_wash` and `dry_wash` inputs, tracks job completion through `done`, and watches `error_signal`. It sits between the user-input logic and the `Washing_Machine` instance and owns all start/config sequencing.

## Interface
Parameters:
- `DEPTH`, default 4: job queue depth; must be a power of 2, minimum 2.
- `START_CYCLES`, default 2: number of cycles `wm_start` is held per launch; minimum 1.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `wm_done` to fall after launch.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: job request.
- `req_double` in 1: job option, double wash.
- `req_dry` in 1: job option, dry wash (steam clean).
- `req_ready` out 1: queue can accept a job.
- `abort` in 1: flush all queued (not yet launched) jobs.
- `clear_fault` in 1: leave the FAULT state.
- `wm_start` out 1: drives controller `start`.
- `wm_double_wash` out 1: drives controller `double_wash`.
- `wm_dry_wash` out 1: drives controller `dry_wash`.
- `wm_done` in 1: from controller `done`.
- `wm_error` in 1: from controller `error_signal`.
- `busy` out 1: state is not IDLE.
- `fault` out 1: state is FAULT.
- `job_done` out 1: one-cycle pulse when a job completes.
- `queue_count` out clog2(DEPTH)+1: number of entries in the queue.
- `jobs_completed` out 8: saturating count of completed jobs.
- `error_events` out 4: saturating count of `wm_error` rising edges.

## Operation
- The queue is a FIFO of {double, dry} entries.
- `req_ready` = (`queue_count` < DEPTH) && !`abort`. A push happens on `req_valid && req_ready`.
- `abort` sets the count to 0 and wins over a same-cycle push or pop. A job already launched is not affected.
- A push and a pop in the same cycle leave the count unchanged. This is legal when the queue is full, but `req_ready` stays low while full.

States:
- IDLE: if `queue_count` > 0 and no abort, pop the head into the current-job registers and go to LAUNCH.
- LAUNCH:
  - `wm_start` = 1, `wm_dry_wash` = cur_dry, `wm_double_wash` = cur_double.
  - After START_CYCLES cycles, go to ARM.
- ARM:
  - `wm_start` = 0 and `wm_dry_wash` = 0; `wm_double_wash` stays at cur_double.
  - When `wm_done` == 0, go to RUN.
  - If ACK_TIMEOUT cycles elapse in ARM with `wm_done` still 1, go to FAULT.
- RUN:
  - `wm_double_wash` is held.
  - On `wm_done` == 1: pulse `job_done`, increment `jobs_completed` (saturating at 255), drop `wm_double_wash`, go to IDLE.
  - `wm_error` does not change state; the controller handles door errors and resumes on its own.
- FAULT: all `wm_*` outputs are 0 and the queue is retained (pushes are still accepted). Only `clear_fault` leaves FAULT, going to IDLE.
- `error_events` increments on each 0→1 transition of `wm_error`, in any state, saturating at 15.

## Timing
- Reset: state IDLE, queue empty. `req_ready` = 1 while `abort` is low. All other outputs are 0, including all counters. Reset applies immediately, mid-job included.
- All outputs are registered except `req_ready`, which is combinational from count and `abort`.
- Launch latency, for a job pushed at edge N into an empty queue in IDLE:
  - The state is IDLE from N, and the pop happens at edge N+1.
  - `wm_start` is high from N+2 for exactly START_CYCLES cycles.
- Completion: `job_done` is high during the cycle after the edge on which RUN samples `wm_done` = 1. The earliest next launch is 1 cycle later (via IDLE).
- The ARM timeout counter counts sampled cycles; it reaches FAULT on the ACK_TIMEOUT-th consecutive cycle with `wm_done` = 1.
- The first job after reset has `wm_done` = 0, so ARM exits after 1 cycle.

## Structure
- Shared package/include `wash_sched_pkg`:
  - State encoding (IDLE = 0, LAUNCH = 1, ARM = 2, RUN = 3, FAULT = 4; 3 bits).
  - Job-entry width (2).
  - Counter saturation constants.
- Sub-module `wash_job_fifo`: parameterised DEPTH×2-bit, with push/pop/flush ports and count. The scheduler FSM and counters are in the top level.

## Test plan
- Reset mid-RUN, then release → state IDLE, `wm_start` = 0, `queue_count` = 0, `jobs_completed` = 0.
- Push {double = 1, dry = 0} at edge N while idle → `wm_start` high for cycles N+2 and N+3 (START_CYCLES = 2) with `wm_double_wash` = 1. Drive `wm_done` 1→0→(later)1 → single `job_done` pulse, `jobs_completed` = 1.
- Push 5 jobs back-to-back with `wm_done` held 0 → `req_ready` low once 4 are queued and one is launched (count 4). The fifth is accepted only after a pop, and jobs launch in FIFO order.
- After one completed job (`wm_done` stays 1), push a job and hold `wm_done` = 1 for 16 cycles → `fault` = 1 and all `wm_*` = 0. Pulse `clear_fault` → IDLE, then the queued job relaunches.
- With 3 jobs queued and one in RUN, assert `abort` for 1 cycle with a same-cycle `req_valid` → `queue_count` = 0, the push is dropped, and the running job still completes with a `job_done` pulse.
- Toggle `wm_error` 0→1→0 three times in RUN → `error_events` = 3 with no state change. Twenty toggles → saturates at 15.
